loadcalc: RTL and testbench

- Load-side counterpart of the store aligner in the M stage.
- Accepts one load request from the pipeline, runs a word-aligned read on the data bus (bridge/DM), and waits for the ack, which may take several cycles.
- Extracts, sign/zero-extends or merges (LWL/LWR) the returned word, then presents one registered result to W.
- Drives a stall while the access is outstanding and flags misaligned addresses and bus timeouts.

---
 rtl/loadcalc_pkg.sv | 26 ++
 rtl/loadcalc_loadext.sv | 45 ++++
 rtl/loadcalc.sv | 108 ++++++++++
 tb/tb_loadcalc.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loadcalc_pkg.sv
// loadcalc_pkg: access-type codes, FSM states and decode helpers shared by the load path
package loadcalc_pkg;

    // Access-type codes, identical to the store aligner's encoding
    localparam logic [2:0] SL_WORD      = 3'd0;
    localparam logic [2:0] SL_HALF      = 3'd1;
    localparam logic [2:0] SL_BYTE      = 3'd2;
    localparam logic [2:0] SL_WORDLEFT  = 3'd3;
    localparam logic [2:0] SL_WORDRIGHT = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_load(input logic [2:0] c);
        return c <= SL_WORDRIGHT;
    endfunction

    // Only word and halfword have alignment rules; LWL/LWR and bytes take any address
    function automatic logic misaligned(input logic [2:0] c, input logic [1:0] b);
        return (c == SL_WORD && b != 2'd0) || (c == SL_HALF && b[0]);
    endfunction

endpackage

// File: rtl/loadcalc_loadext.sv
// loadext: combinational extraction, extension and LWL/LWR merge of a returned bus word
//   m    : word returned by the bus
//   b    : byte offset of the load address
//   ctrl : access type
//   sign : 1 = sign-extend byte/half
//   rt   : old rt value, kept in the bytes LWL/LWR do not replace
//   word : load result
module loadext
    import loadcalc_pkg::*;
(
    input  logic [31:0] m,
    input  logic [1:0]  b,
    input  logic [2:0]  ctrl,
    input  logic        sign,
    input  logic [31:0] rt,
    output logic [31:0] word
);

    logic [4:0]  lsh;
    logic [4:0]  rsh;
    logic [31:0] lmask;
    logic [31:0] rmask;
    logic [31:0] sm;
    logic [15:0] h;
    logic [7:0]  y;

    // 8*(3-b) equals {~b,3'b000} for a 2-bit offset
    assign lsh   = {~b, 3'b000};
    assign rsh   = {b, 3'b000};
    assign lmask = 32'hFFFF_FFFF << lsh;
    assign rmask = 32'hFFFF_FFFF >> rsh;
    assign sm    = m >> rsh;
    assign h     = b[1] ? m[31:16] : m[15:0];
    assign y     = sm[7:0];

    always_comb begin
        word = ctrl == SL_WORD      ? m :
               ctrl == SL_HALF      ? {{16{sign & h[15]}}, h} :
               ctrl == SL_BYTE      ? {{24{sign & y[7]}}, y} :
               ctrl == SL_WORDLEFT  ? ((m << lsh) & lmask) | (rt & ~lmask) :
               ctrl == SL_WORDRIGHT ? (sm & rmask) | (rt & ~rmask) :
                                      32'h0;
    end

endmodule

// File: rtl/loadcalc.sv
// loadcalc: M-stage load unit - bus read, wait for ack, extract/merge, one registered result to W
//   Req/Adrin/SLCtrl/LdSign/RtOld : load request, sampled in IDLE/DONE
//   Flush                         : abort outstanding load, drop a request in the same cycle
//   BusAddr/BusRd/BusRData/BusAck : word-aligned read on the data bus
//   Dout/DoutValid                : load result and its one-cycle valid pulse
//   Busy                          : pipeline stall
//   AdEL/BusErr                   : misaligned-load and ack-timeout pulses
module loadcalc
    import loadcalc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 8
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Req,
    input  logic [31:0] Adrin,
    input  logic [2:0]  SLCtrl,
    input  logic        LdSign,
    input  logic [31:0] RtOld,
    input  logic        Flush,
    output logic [31:0] BusAddr,
    output logic        BusRd,
    input  logic [31:0] BusRData,
    input  logic        BusAck,
    output logic [31:0] Dout,
    output logic        DoutValid,
    output logic        Busy,
    output logic        AdEL,
    output logic        BusErr
);

    state_e      state;
    logic [CNTW-1:0] cnt;
    logic [2:0]  ctrl;
    logic        sign;
    logic [1:0]  bsel;
    logic [31:0] rt;
    logic [31:0] ext;
    logic        take;
    logic        mis;

    // A flushed cycle never accepts, so a request alongside Flush is simply lost
    assign take = state != S_REQ && Req && !Flush && is_load(SLCtrl);
    assign mis  = misaligned(SLCtrl, Adrin[1:0]);

    assign BusRd     = state == S_REQ;
    assign DoutValid = state == S_DONE;
    assign Busy      = BusRd || (take && !mis);

    loadext u_ext (
        .m    (BusRData),
        .b    (bsel),
        .ctrl (ctrl),
        .sign (sign),
        .rt   (rt),
        .word (ext)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ctrl    <= '0;
            sign    <= 1'b0;
            bsel    <= '0;
            rt      <= '0;
            BusAddr <= '0;
            Dout    <= '0;
            AdEL    <= 1'b0;
            BusErr  <= 1'b0;
        end else begin
            AdEL   <= 1'b0;
            BusErr <= 1'b0;
            if (take) begin
                ctrl    <= SLCtrl;
                sign    <= LdSign;
                bsel    <= Adrin[1:0];
                rt      <= RtOld;
                BusAddr <= {Adrin[31:2], 2'b00};
                cnt     <= '0;
                AdEL    <= mis;
                state   <= mis ? S_IDLE : S_REQ;
            end else begin
                case (state)
                    S_REQ: begin
                        if (Flush) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end else if (BusAck) begin
                            Dout  <= ext;
                            state <= S_DONE;
                        end else if (cnt == CNTW'(TIMEOUT - 1)) begin
                            BusErr <= 1'b1;
                            state  <= S_IDLE;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_loadcalc.sv
// tb_loadcalc: randomized load transactions checked against a byte-level reference model
module tb_loadcalc;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Req = 1'b0;
    logic [31:0] Adrin = '0;
    logic [2:0]  SLCtrl = '0;
    logic        LdSign = 1'b0;
    logic [31:0] RtOld = '0;
    logic        Flush = 1'b0;
    logic [31:0] BusRData = '0;
    logic        BusAck = 1'b0;
    logic [31:0] BusAddr;
    logic        BusRd;
    logic [31:0] Dout;
    logic        DoutValid;
    logic        Busy;
    logic        AdEL;
    logic        BusErr;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_dout = '0;

    always #5 clk = ~clk;

    loadcalc #(.TIMEOUT(TO), .CNTW(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Req       (Req),
        .Adrin     (Adrin),
        .SLCtrl    (SLCtrl),
        .LdSign    (LdSign),
        .RtOld     (RtOld),
        .Flush     (Flush),
        .BusAddr   (BusAddr),
        .BusRd     (BusRd),
        .BusRData  (BusRData),
        .BusAck    (BusAck),
        .Dout      (Dout),
        .DoutValid (DoutValid),
        .Busy      (Busy),
        .AdEL      (AdEL),
        .BusErr    (BusErr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: result assembled byte by byte from the memory word and old rt
    function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [1:0] b, input logic s,
                                             input logic [31:0] m, input logic [31:0] rt);
        logic [7:0]  mb [4];
        logic [7:0]  rb [4];
        logic [7:0]  ob [4];
        logic [15:0] h;
        int          k;
        k = int'(b);
        for (int i = 0; i < 4; i++) begin
            mb[i] = m[8*i +: 8];
            rb[i] = rt[8*i +: 8];
        end
        case (c)
            3'd0: return m;
            3'd1: begin
                h = (k >= 2) ? {mb[3], mb[2]} : {mb[1], mb[0]};
                return (s && h[15]) ? {16'hFFFF, h} : {16'h0000, h};
            end
            3'd2: return (s && mb[k][7]) ? {24'hFFFFFF, mb[k]} : {24'h0, mb[k]};
            3'd3: begin
                for (int i = 0; i < 4; i++) ob[i] = (i >= 3 - k) ? mb[i - (3 - k)] : rb[i];
                return {ob[3], ob[2], ob[1], ob[0]};
            end
            3'd4: begin
                for (int i = 0; i < 4; i++) ob[i] = (i <= 3 - k) ? mb[i + k] : rb[i];
                return {ob[3], ob[2], ob[1], ob[0]};
            end
            default: return 32'h0;
        endcase
    endfunction

    // One request; ack arrives in REQ cycle 'waits' (>= TO means never), Flush in REQ cycle 'fl'
    task automatic run_load(input logic [2:0] c, input logic [31:0] a, input logic s, input logic [31:0] rt,
                            input logic [31:0] m, input int waits, input int fl);
        logic        is_ld;
        logic        mis;
        logic [31:0] exp;
        is_ld = c <= 3'd4;
        mis   = (c == 3'd0 && a[1:0] != 2'd0) || (c == 3'd1 && a[0]);
        Req = 1'b1; SLCtrl = c; Adrin = a; LdSign = s; RtOld = rt;
        #1;
        check("busy_accept", Busy, is_ld && !mis);
        step();
        Req = 1'b0; Adrin = $urandom; RtOld = $urandom; SLCtrl = 3'($urandom); LdSign = 1'($urandom);
        if (!is_ld) begin
            check("nonload_rd", BusRd, 0);
            check("nonload_adel", AdEL, 0);
            return;
        end
        if (mis) begin
            check("adel", AdEL, 1);
            check("adel_rd", BusRd, 0);
            check("adel_busy", Busy, 0);
            step();
            check("adel_pulse", AdEL, 0);
            check("adel_dv", DoutValid, 0);
            check("adel_rd2", BusRd, 0);
            return;
        end
        for (int k = 0; k < TO; k++) begin
            check("req_rd", BusRd, 1);
            check("req_busy", Busy, 1);
            check("req_addr", BusAddr, {a[31:2], 2'b00});
            check("req_dv", DoutValid, 0);
            BusAck = (k == waits);
            BusRData = (k == waits) ? m : $urandom;
            Flush = (k == fl);
            step();
            BusAck = 1'b0;
            Flush = 1'b0;
            if (k == fl) begin
                check("flush_rd", BusRd, 0);
                check("flush_dv", DoutValid, 0);
                check("flush_dout", Dout, last_dout);
                break;
            end
            if (k == waits) begin
                exp = ref_load(c, a[1:0], s, m, rt);
                last_dout = exp;
                check("done_dv", DoutValid, 1);
                check("done_dout", Dout, exp);
                check("done_busy", Busy, 0);
                check("done_rd", BusRd, 0);
                break;
            end
            if (k == TO - 1) begin
                check("berr", BusErr, 1);
                check("berr_rd", BusRd, 0);
                check("berr_dout", Dout, last_dout);
                break;
            end
            check("berr_early", BusErr, 0);
        end
        step();
        check("dv_pulse", DoutValid, 0);
        check("berr_pulse", BusErr, 0);
        check("idle_rd", BusRd, 0);
    endtask

    initial begin
        logic [2:0] c;
        int         w;
        int         f;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", BusAddr, 0);
        check("rst_dout", Dout, 0);
        check("rst_rd", BusRd, 0);
        check("rst_dv", DoutValid, 0);
        check("rst_busy", Busy, 0);
        check("rst_adel", AdEL, 0);
        check("rst_berr", BusErr, 0);
        reset_n = 1'b1;
        step();

        run_load(3'd2, 32'h0000_1003, 1'b1, 32'h0, 32'h80AB_CD12, 0, 99);
        check("tp_lb", Dout, 32'hFFFF_FF80);
        run_load(3'd1, 32'h0000_1002, 1'b0, 32'h0, 32'h8001_7FFF, 3, 99);
        check("tp_lhu", Dout, 32'h0000_8001);
        run_load(3'd3, 32'h0000_3001, 1'b0, 32'hAABB_CCDD, 32'h4433_2211, 1, 99);
        check("tp_lwl", Dout, 32'h2211_CCDD);
        run_load(3'd4, 32'h0000_3002, 1'b0, 32'hAABB_CCDD, 32'h4433_2211, 0, 99);
        check("tp_lwr", Dout, 32'hAABB_4433);
        run_load(3'd0, 32'h0000_2002, 1'b0, 32'h0, 32'h1234_5678, 0, 99);
        run_load(3'd0, 32'h0000_2000, 1'b0, 32'h0, 32'h1234_5678, 99, 99);
        run_load(3'd0, 32'h0000_2004, 1'b0, 32'h0, 32'h1234_5678, 2, 2);
        run_load(3'd6, 32'h0000_2008, 1'b0, 32'h0, 32'h1234_5678, 0, 99);

        // Back-to-back words with Req held through DONE
        Req = 1'b1; SLCtrl = 3'd0; Adrin = 32'h0;
        step();
        check("b2b_rd1", BusRd, 1);
        check("b2b_addr1", BusAddr, 32'h0);
        Adrin = 32'h4; BusAck = 1'b1; BusRData = 32'hCAFE_0001;
        step();
        BusAck = 1'b0;
        #1;
        check("b2b_dv1", DoutValid, 1);
        check("b2b_dout1", Dout, 32'hCAFE_0001);
        check("b2b_busy", Busy, 1);
        step();
        check("b2b_rd2", BusRd, 1);
        check("b2b_addr2", BusAddr, 32'h4);
        check("b2b_dv_gap", DoutValid, 0);
        Req = 1'b0; BusAck = 1'b1; BusRData = 32'hCAFE_0002;
        step();
        BusAck = 1'b0;
        check("b2b_dv2", DoutValid, 1);
        check("b2b_dout2", Dout, 32'hCAFE_0002);
        last_dout = 32'hCAFE_0002;
        step();
        check("b2b_end", DoutValid, 0);

        // Flush alongside a legal request drops it
        Req = 1'b1; SLCtrl = 3'd0; Adrin = 32'h10; Flush = 1'b1;
        #1;
        check("flush_acc_busy", Busy, 0);
        step();
        Req = 1'b0; Flush = 1'b0;
        check("flush_acc_rd", BusRd, 0);

        for (int t = 0; t < 300; t++) begin
            c = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            w = $urandom_range(0, 5) == 0 ? $urandom_range(0, TO + 2) : $urandom_range(0, 4);
            f = $urandom_range(0, 7) == 0 ? $urandom_range(0, 5) : 99;
            run_load(c, $urandom, 1'($urandom), $urandom, $urandom, w, f);
            if ($urandom_range(0, 3) == 0) step();
        end

        // Reset mid-REQ clears everything at once
        Req = 1'b1; SLCtrl = 3'd0; Adrin = 32'h8;
        step();
        Req = 1'b0;
        check("mid_rd", BusRd, 1);
        reset_n = 1'b0;
        #1;
        check("arst_rd", BusRd, 0);
        check("arst_busy", Busy, 0);
        check("arst_addr", BusAddr, 0);
        check("arst_dout", Dout, 0);
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_rd", BusRd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
